// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready output buffer with framing-error and overrun pulses.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} stateT;

  logic                  rxdMeta;
  logic                  rxdSync;
  stateT                 state;
  stateT                 nextState;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cntNext;
  logic [IDX_W-1:0]      bitIdx;
  logic [IDX_W-1:0]      bitIdxNext;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic [DATA_WIDTH-1:0] shiftNext;
  logic                  sampleHalf;
  logic                  sampleFull;
  logic                  lastBit;
  logic                  byteDoneC;
  logic                  frameErrC;

  assign sampleHalf = (cnt == CNT_W'(HALF - 1));
  assign sampleFull = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign lastBit    = (bitIdx == IDX_W'(DATA_WIDTH - 1));

  // Synchronizer resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxdMeta <= 1'b1;
      rxdSync <= 1'b1;
    end else begin
      rxdMeta <= rxd;
      rxdSync <= rxdMeta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (!rxdSync)   nextState = START;
      START:   if (sampleHalf) nextState = rxdSync ? IDLE : DATA;
      DATA:    if (sampleFull && lastBit) nextState = STOP;
      STOP:    if (sampleFull) nextState = rxdSync ? IDLE : BREAK;
      BREAK:   if (rxdSync)    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Every state change coincides with a sample or an idle/break exit, so zeroing cnt there covers both.
  always_comb begin
    cntNext    = cnt + CNT_W'(1);
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    byteDoneC  = 1'b0;
    frameErrC  = 1'b0;
    case (state)
      IDLE, BREAK: cntNext = '0;
      START: begin
        if (sampleHalf) begin
          cntNext    = '0;
          bitIdxNext = '0;
        end
      end
      DATA: begin
        if (sampleFull) begin
          cntNext           = '0;
          shiftNext[bitIdx] = rxdSync;
          bitIdxNext        = bitIdx + IDX_W'(1);
        end
      end
      STOP: begin
        if (sampleFull) begin
          cntNext   = '0;
          byteDoneC = rxdSync;
          frameErrC = !rxdSync;
        end
      end
      default: cntNext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      cnt      <= cntNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
    end
  end

  // Single-entry buffer: a completion may refill it in the same cycle it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= frameErrC;
      overrun   <= byteDoneC && data_valid && !data_ready;
      if (byteDoneC && (!data_valid || data_ready)) begin
        data       <= shiftReg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: directed scenarios plus randomized
// frames, glitches and framing errors against a byte-level expectation queue.
module tb_uart_rx_deserializer;

  localparam int unsigned CPB = 16;
  localparam int unsigned DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rxd;
  logic          data_ready;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          frame_err;
  logic          overrun;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int passes      = 0;
  int frameErrCnt = 0;
  int overrunCnt  = 0;
  int expFrameErr = 0;
  int expOverrun  = 0;
  logic [DW-1:0] expQ[$];
  logic prevFe = 1'b0;
  logic prevOv = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference model at frame granularity: a good frame lands in the buffer unless
  // the buffer is still occupied and not being consumed at completion.
  task automatic expectFrame(input logic [DW-1:0] b, input bit stopOk, input bit readyAtDone);
    if (!stopOk) expFrameErr++;
    else if (expQ.size() != 0 && !readyAtDone) expOverrun++;
    else expQ.push_back(b);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic sendBit(input logic v);
    rxd = v;
    tick(CPB);
  endtask

  task automatic sendFrame(input logic [DW-1:0] b, input logic stopBit);
    sendBit(1'b0);
    for (int i = 0; i < DW; i++) sendBit(b[i]);
    sendBit(stopBit);
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 400 && expQ.size() != 0; i++) tick(1);
    check({tag, " drained"}, expQ.size(), 0);
    check({tag, " frame_err count"}, frameErrCnt, expFrameErr);
    check({tag, " overrun count"}, overrunCnt, expOverrun);
  endtask

  // Monitor: consumes expectations on each handshake, checks held data and pulse widths.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) begin
        frameErrCnt++;
        check("frame_err single cycle", prevFe, 0);
      end
      if (overrun) begin
        overrunCnt++;
        check("overrun single cycle", prevOv, 0);
      end
      if (data_valid) begin
        if (expQ.size() == 0) check("unexpected data_valid", data_valid, 0);
        else begin
          check("data", data, expQ[0]);
          if (data_ready) void'(expQ.pop_front());
        end
      end
      prevFe = frame_err;
      prevOv = overrun;
    end else begin
      prevFe = 1'b0;
      prevOv = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] b;
    int kind;
    rst_n      = 1'b0;
    rxd        = 1'b1;
    data_ready = 1'b1;
    tick(3);
    check("reset data", data, 0);
    check("reset data_valid", data_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    rst_n = 1'b1;
    tick(5);

    // Back-to-back frames with the consumer always ready.
    expectFrame(8'h55, 1, 1);
    sendFrame(8'h55, 1'b1);
    expectFrame(8'hA3, 1, 1);
    sendFrame(8'hA3, 1'b1);
    tick(5);
    settle("b2b");

    // Short low glitch is rejected at the half-bit check.
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(20);
    settle("glitch");

    // Low stop bit followed by a held break, then a clean frame.
    expectFrame(8'h3C, 0, 1);
    sendFrame(8'h3C, 1'b0);
    tick(40);
    rxd = 1'b1;
    tick(6);
    expectFrame(8'h81, 1, 1);
    sendFrame(8'h81, 1'b1);
    tick(5);
    settle("break");

    // Overrun: second byte dropped while the first is held.
    data_ready = 1'b0;
    expectFrame(8'h11, 1, 0);
    sendFrame(8'h11, 1'b1);
    expectFrame(8'h22, 1, 0);
    sendFrame(8'h22, 1'b1);
    tick(5);
    check("overrun held valid", data_valid, 1);
    check("overrun held data", data, 8'h11);
    check("overrun pulse count", overrunCnt, expOverrun);
    data_ready = 1'b1;
    tick(2);
    check("overrun drained valid", data_valid, 0);
    check("overrun data kept", data, 8'h11);
    settle("overrun");

    // Consumer becomes ready exactly on the completion edge of the second byte.
    data_ready = 1'b0;
    expectFrame(8'h01, 1, 0);
    sendFrame(8'h01, 1'b1);
    tick(3);
    expectFrame(8'h7E, 1, 1);
    fork
      sendFrame(8'h7E, 1'b1);
      begin
        tick(2 + 1 + CPB / 2 + (DW + 1) * CPB - 1);
        check("pre-completion valid", data_valid, 1);
        check("pre-completion data", data, 8'h01);
        data_ready = 1'b1;
        tick(1);
        check("same-cycle refill valid", data_valid, 1);
        check("same-cycle refill data", data, 8'h7E);
      end
    join
    tick(3);
    settle("refill");

    // Asynchronous reset mid-frame with a byte held in the buffer.
    data_ready = 1'b0;
    expectFrame(8'h99, 1, 0);
    sendFrame(8'h99, 1'b1);
    tick(3);
    b = 8'hF0;
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(b[i]);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset data", data, 0);
    check("async reset data_valid", data_valid, 0);
    check("async reset frame_err", frame_err, 0);
    check("async reset overrun", overrun, 0);
    expQ.delete();
    rxd        = 1'b1;
    data_ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick(20);
    expectFrame(8'h5A, 1, 1);
    sendFrame(8'h5A, 1'b1);
    tick(5);
    settle("reset");

    // Randomized mix of good frames, glitches and framing errors.
    repeat (25) begin
      kind = int'($urandom_range(0, 9));
      b    = DW'($urandom);
      if (kind < 7) begin
        expectFrame(b, 1, 1);
        sendFrame(b, 1'b1);
        tick(int'($urandom_range(0, 20)));
      end else if (kind == 7) begin
        rxd = 1'b0;
        tick(int'($urandom_range(1, 4)));
        rxd = 1'b1;
        tick(int'($urandom_range(14, 24)));
      end else begin
        expectFrame(b, 0, 1);
        sendFrame(b, 1'b0);
        tick(int'($urandom_range(0, 30)));
        rxd = 1'b1;
        tick(int'($urandom_range(4, 12)));
      end
    end
    tick(5);
    settle("random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
